// File: rtl/data_mem_lsu.sv
// data_mem_lsu: MEM-stage data memory with byte/half/word/double load-store unit and post-reset clear.
// Optional: define DMEM_DEBUG_PORT_EN to add a combinational full-word debug read port (dbg_addr/dbg_data).
`timescale 1ns/1ps
module data_mem_lsu #(
    parameter int DATA      = 32,
    parameter int ADDR      = 32,
    parameter int MEM_DEPTH = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [ADDR-1:0]              req_addr,
    input  logic [1:0]                   req_size,
    input  logic                         req_unsigned,
    input  logic [DATA-1:0]              req_wdata,
    output logic                         rsp_valid,
    output logic [DATA-1:0]              rsp_rdata,
    output logic                         rsp_err,
`ifdef DMEM_DEBUG_PORT_EN
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
    output logic [DATA-1:0]              dbg_data,
`endif
    output logic                         busy
);
    localparam int NBYTES = DATA / 8;
    localparam int OFFB   = $clog2(NBYTES);
    localparam int IDXW   = $clog2(MEM_DEPTH);
    localparam int WIDXW  = ADDR - OFFB;
    localparam int SHW    = $clog2(DATA);

    typedef enum logic {CLEAR, READY} state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] clr_ptr;
    logic [DATA-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR) clr_ptr <= clr_ptr + 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        busy      = 1'b1;
        req_ready = 1'b0;
        case (state_q)
            CLEAR: if (clr_ptr == IDXW'(MEM_DEPTH - 1)) state_d = READY;
            READY: begin
                busy      = 1'b0;
                req_ready = 1'b1;
            end
        endcase
        if (rst) begin
            busy      = 1'b1;
            req_ready = 1'b0;
        end
    end

    // Address decode and error detection
    logic [OFFB-1:0]  offset;
    logic [WIDXW-1:0] word_full;
    logic [IDXW-1:0]  idx;
    logic             in_range;
    logic [3:0]       acc_bytes;
    logic [6:0]       acc_bits;
    logic             size_bad, misaligned, acc_err, accept, wr_en;

    assign offset    = req_addr[OFFB-1:0];
    assign word_full = req_addr[ADDR-1:OFFB];
    assign idx       = word_full[IDXW-1:0];

    generate
        if (WIDXW > IDXW) begin : g_range
            assign in_range = ~|word_full[WIDXW-1:IDXW];
        end else begin : g_full
            assign in_range = 1'b1;
        end
    endgenerate

    assign acc_bytes  = 4'd1 << req_size;
    assign acc_bits   = 7'd8 << req_size;
    assign size_bad   = (DATA == 32) && (req_size == 2'b11);
    assign misaligned = |(offset & OFFB'(acc_bytes - 4'd1));
    assign acc_err    = size_bad | misaligned | ~in_range;
    assign accept     = req_valid & req_ready;
    assign wr_en      = accept & req_we & ~acc_err;

    // Store path: lane enables and write data shifted up to the addressed lanes
    logic [NBYTES-1:0] lane_sel, byte_en;
    logic [DATA-1:0]   wdata_al;

    assign lane_sel = ~({NBYTES{1'b1}} << acc_bytes);
    assign byte_en  = lane_sel << offset;
    assign wdata_al = req_wdata << {offset, 3'b000};

    // NOTE: the array has no reset branch; it is zeroed only by the clear sequencer.
    always_ff @(posedge clk) begin
        if (!rst && state_q == CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < NBYTES; b++)
                if (byte_en[b]) mem[idx][8*b +: 8] <= wdata_al[8*b +: 8];
        end
    end

    // Load path: right-align, then mask and extend from the top selected bit
    logic [DATA-1:0] rd_shift, val_mask, load_val;
    logic [SHW-1:0]  sign_idx;
    logic            sign_bit;

    assign rd_shift = mem[idx] >> {offset, 3'b000};
    assign val_mask = ~({DATA{1'b1}} << acc_bits);
    assign sign_idx = SHW'(acc_bits - 7'd1);
    assign sign_bit = rd_shift[sign_idx] & ~req_unsigned;
    assign load_val = (rd_shift & val_mask) | ({DATA{sign_bit}} & ~val_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= accept;
            rsp_err   <= accept & acc_err;
            rsp_rdata <= (accept && !req_we && !acc_err) ? load_val : '0;
        end
    end

`ifdef DMEM_DEBUG_PORT_EN
    assign dbg_data = mem[dbg_addr];
`endif

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: directed and randomized checks of data_mem_lsu against a byte-array reference model.
`timescale 1ns/1ps
module tb_data_mem_lsu;
    localparam int DATA      = 32;
    localparam int ADDR      = 32;
    localparam int MEM_DEPTH = 256;
    localparam int NBYTES    = DATA / 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [ADDR-1:0] req_addr = '0;
    logic [1:0]      req_size = '0;
    logic [DATA-1:0] req_wdata = '0;
    logic            req_ready, rsp_valid, rsp_err, busy;
    logic [DATA-1:0] rsp_rdata;
`ifdef DMEM_DEBUG_PORT_EN
    logic [$clog2(MEM_DEPTH)-1:0] dbg_addr = '0;
    logic [DATA-1:0]              dbg_data;
`endif

    int checks = 0;
    int errors = 0;

    byte unsigned model_mem [MEM_DEPTH*NBYTES];

    data_mem_lsu #(.DATA(DATA), .ADDR(ADDR), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
`ifdef DMEM_DEBUG_PORT_EN
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    // Reference: memory as a flat byte array, accesses computed with plain arithmetic.
    function automatic void model_exec(input logic we, input logic [ADDR-1:0] a, input logic [1:0] sz,
                                       input logic u, input logic [DATA-1:0] wd,
                                       output logic [DATA-1:0] rd, output logic er);
        longint unsigned widx = longint'(a) / NBYTES;
        int              off  = int'(a % NBYTES);
        int              nb   = 1 << sz;
        logic [63:0]     v    = 64'd0;
        er = (sz == 2'd3 && DATA == 32) || (off % nb != 0) || (widx >= MEM_DEPTH);
        rd = '0;
        if (er) return;
        if (we) begin
            for (int i = 0; i < nb; i++)
                model_mem[int'(widx)*NBYTES + off + i] = 8'(wd >> (8*i));
        end else begin
            for (int i = nb - 1; i >= 0; i--)
                v = (v << 8) | 64'(model_mem[int'(widx)*NBYTES + off + i]);
            if (!u && nb * 8 < 64 && v[nb*8-1]) v = v | (~64'd0 << (nb * 8));
            rd = DATA'(v);
        end
    endfunction

    task automatic xact(input logic we, input logic [ADDR-1:0] a, input logic [1:0] sz, input logic u,
                        input logic [DATA-1:0] wd, output logic [DATA-1:0] rd, output logic er,
                        output logic vl, output logic [DATA-1:0] md, output logic me);
        @(negedge clk);
        req_we = we; req_addr = a; req_size = sz; req_unsigned = u; req_wdata = wd; req_valid = 1'b1;
        model_exec(we, a, sz, u, wd, md, me);
        @(negedge clk);
        req_valid = 1'b0;
        rd = rsp_rdata; er = rsp_err; vl = rsp_valid;
    endtask

    // Releases rst (caller sits between edges) and counts cycles with busy high.
    task automatic count_clear(output int n);
        rst = 1'b0;
        #1;
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
            #1;
        end
        for (int i = 0; i < MEM_DEPTH*NBYTES; i++) model_mem[i] = 8'h00;
    endtask

    task automatic pulse_rst(output int n);
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        count_clear(n);
    endtask

    task automatic test_reset();
        int n;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy, req_ready} !== 2'b10) begin
            errors++; $display("FAIL reset_busy_ready got %b required 10", {busy, req_ready});
        end
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== '0) begin
            errors++; $display("FAIL reset_rsp got v=%b e=%b d=%h required all 0", rsp_valid, rsp_err, rsp_rdata);
        end
        count_clear(n);
        checks++;
        if (n != MEM_DEPTH) begin errors++; $display("FAIL reset_clear_len got %0d required %0d", n, MEM_DEPTH); end
        checks++;
        if ({busy, req_ready} !== 2'b01) begin
            errors++; $display("FAIL ready_after_clear got %b required 01", {busy, req_ready});
        end
    endtask

    task automatic test_clear();
        logic [DATA-1:0] rd, md; logic er, vl, me; int n;
        for (int w = 0; w < MEM_DEPTH; w++)
            xact(1'b1, ADDR'(w * NBYTES), 2'd2, 1'b0, DATA'($urandom | 1), rd, er, vl, md, me);
        xact(1'b0, ADDR'(5 * NBYTES), 2'd2, 1'b0, '0, rd, er, vl, md, me);
        checks++;
        if (rd !== md || md == '0) begin errors++; $display("FAIL preload_readback got %h required %h (nonzero)", rd, md); end
        pulse_rst(n);
        checks++;
        if (n != MEM_DEPTH) begin errors++; $display("FAIL clear_len got %0d required %0d", n, MEM_DEPTH); end
        for (int w = 0; w < MEM_DEPTH; w++) begin
            xact(1'b0, ADDR'(w * NBYTES), 2'd2, 1'b0, '0, rd, er, vl, md, me);
            checks++;
            if ({vl, er, rd} !== {1'b1, 1'b0, {DATA{1'b0}}}) begin
                errors++; $display("FAIL clear_word[%0d] got v=%b e=%b d=%h required v=1 e=0 d=0", w, vl, er, rd);
            end
        end
    endtask

    task automatic test_bytes();
        logic [DATA-1:0] rd, md; logic er, vl, me;
        xact(1'b1, 'h10, 2'd2, 1'b0, 32'h0000_0000, rd, er, vl, md, me);
        checks++;
        if ({vl, er} !== 2'b10) begin errors++; $display("FAIL sw_rsp got v=%b e=%b required v=1 e=0", vl, er); end
        xact(1'b1, 'h11, 2'd0, 1'b0, 32'hAAAA_AA85, rd, er, vl, md, me);
        checks++;
        if ({vl, er, rd} !== {2'b10, 32'h0}) begin errors++; $display("FAIL sb_rsp got v=%b e=%b d=%h required 1 0 0", vl, er, rd); end
        xact(1'b0, 'h11, 2'd0, 1'b1, '0, rd, er, vl, md, me);
        checks++;
        if (rd !== 32'h0000_0085) begin errors++; $display("FAIL lbu got %h required 00000085", rd); end
        xact(1'b0, 'h11, 2'd0, 1'b0, '0, rd, er, vl, md, me);
        checks++;
        if (rd !== 32'hFFFF_FF85) begin errors++; $display("FAIL lb got %h required ffffff85", rd); end
        xact(1'b0, 'h10, 2'd2, 1'b1, '0, rd, er, vl, md, me);
        checks++;
        if (rd !== 32'h0000_8500) begin errors++; $display("FAIL lw_after_sb got %h required 00008500", rd); end
`ifdef DMEM_DEBUG_PORT_EN
        dbg_addr = 4;
        #1;
        checks++;
        if (dbg_data !== 32'h0000_8500) begin errors++; $display("FAIL dbg_read got %h required 00008500", dbg_data); end
`endif
    endtask

    task automatic test_half_b2b();
        logic [DATA-1:0] rd, md; logic er, vl, me;
        @(negedge clk);
        req_we = 1'b1; req_addr = 'h22; req_size = 2'd1; req_unsigned = 1'b0; req_wdata = 32'h1234_8001; req_valid = 1'b1;
        model_exec(1'b1, 'h22, 2'd1, 1'b0, 32'h1234_8001, md, me);
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_err} !== 2'b10) begin errors++; $display("FAIL sh_rsp got v=%b e=%b required 1 0", rsp_valid, rsp_err); end
        req_we = 1'b0; req_wdata = '0;
        model_exec(1'b0, 'h22, 2'd1, 1'b0, '0, md, me);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hFFFF_8001}) begin
            errors++; $display("FAIL lh_b2b got v=%b e=%b d=%h required 1 0 ffff8001", rsp_valid, rsp_err, rsp_rdata);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_one_cycle got %b required 0", rsp_valid); end
        xact(1'b0, 'h22, 2'd1, 1'b1, '0, rd, er, vl, md, me);
        checks++;
        if (rd !== 32'h0000_8001) begin errors++; $display("FAIL lhu got %h required 00008001", rd); end
    endtask

    task automatic test_errors();
        logic [DATA-1:0] rd, md; logic er, vl, me;
        xact(1'b1, 'h00, 2'd2, 1'b0, 32'h1234_5678, rd, er, vl, md, me);
        xact(1'b0, 'h06, 2'd2, 1'b0, '0, rd, er, vl, md, me);
        checks++;
        if ({vl, er, rd} !== {2'b11, 32'h0}) begin errors++; $display("FAIL lw_misaligned got v=%b e=%b d=%h required 1 1 0", vl, er, rd); end
        xact(1'b1, 'h03, 2'd1, 1'b0, 32'h0000_BEEF, rd, er, vl, md, me);
        checks++;
        if ({vl, er} !== 2'b11) begin errors++; $display("FAIL sh_misaligned got v=%b e=%b required 1 1", vl, er); end
        xact(1'b0, 'h00, 2'd2, 1'b0, '0, rd, er, vl, md, me);
        checks++;
        if (rd !== 32'h1234_5678) begin errors++; $display("FAIL word0_untouched got %h required 12345678", rd); end
        xact(1'b0, 'h400, 2'd2, 1'b0, '0, rd, er, vl, md, me);
        checks++;
        if ({er, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL lw_out_of_range got e=%b d=%h required 1 0", er, rd); end
        xact(1'b0, 'h20, 2'd3, 1'b0, '0, rd, er, vl, md, me);
        checks++;
        if ({er, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL size3_on_32 got e=%b d=%h required 1 0", er, rd); end
        xact(1'b1, 'h3FC, 2'd2, 1'b0, 32'hCAFE_F00D, rd, er, vl, md, me);
        xact(1'b0, 'h3FC, 2'd2, 1'b0, '0, rd, er, vl, md, me);
        checks++;
        if ({er, rd} !== {1'b0, 32'hCAFE_F00D}) begin errors++; $display("FAIL last_word got e=%b d=%h required 0 cafef00d", er, rd); end
    endtask

    // Random request stream with ~75% valid density; each response checked one cycle later.
    task automatic test_random_stream(input int n);
        logic exp_v = 1'b0, exp_e = 1'b0;
        logic [DATA-1:0] exp_d = '0;
        logic we, u;
        logic [ADDR-1:0] a;
        logic [1:0] sz;
        logic [DATA-1:0] wd;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== exp_v) begin errors++; $display("FAIL stream_valid[%0d] got %b required %b", i, rsp_valid, exp_v); end
            if (exp_v) begin
                checks++;
                if (rsp_rdata !== exp_d || rsp_err !== exp_e) begin
                    errors++; $display("FAIL stream_rsp[%0d] got d=%h e=%b required d=%h e=%b", i, rsp_rdata, rsp_err, exp_d, exp_e);
                end
            end
            exp_v = 1'b0;
            if (i < n && $urandom_range(0, 3) != 0) begin
                we = 1'($urandom); u = 1'($urandom); sz = 2'($urandom); wd = DATA'($urandom);
                case ($urandom_range(0, 7))
                    0:       a = ADDR'($urandom);
                    1, 2, 3: a = ADDR'($urandom_range(0, 63));
                    default: a = ADDR'($urandom_range(0, MEM_DEPTH*NBYTES - 1));
                endcase
                if ($urandom_range(0, 1) == 1) a = a & ~ADDR'((1 << sz) - 1);
                req_we = we; req_addr = a; req_size = sz; req_unsigned = u; req_wdata = wd; req_valid = 1'b1;
                model_exec(we, a, sz, u, wd, exp_d, exp_e);
                exp_v = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        req_we = 1'b0; req_addr = 'h10; req_size = 2'd2; req_unsigned = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({rsp_valid, busy, req_ready} !== 3'b010) begin
            errors++; $display("FAIL reset_mid_drop got v=%b busy=%b ready=%b required 0 1 0", rsp_valid, busy, req_ready);
        end
        count_clear(n);
        checks++;
        if (n != MEM_DEPTH) begin errors++; $display("FAIL reset_mid_clear_len got %0d required %0d", n, MEM_DEPTH); end
    endtask

    task automatic test_reset_in_clear();
        int n;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        pulse_rst(n);
        checks++;
        if (n != MEM_DEPTH) begin errors++; $display("FAIL reclear_len got %0d required %0d", n, MEM_DEPTH); end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_bytes();
        test_half_b2b();
        test_errors();
        test_random_stream(400);
        test_reset_mid();
        test_random_stream(60);
        test_reset_in_clear();
        test_random_stream(200);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
